// File: rtl/biss_crc_if.sv
// Receiver-side bundle between the BiSS-C frame receiver and the CRC checker.
// The receiver drives the frame fields; the checker returns results and status.
interface biss_crc_if;
   logic        crc_en;
   logic [25:0] data_in;
   logic [1:0]  err_in;
   logic [5:0]  crc_in;
   logic [25:0] angle_out;
   logic [1:0]  err_out;
   logic        angle_valid;
   logic        crc_fail;
   logic [15:0] fail_cnt;
   logic        alarm;
   logic        stale;
   logic        busy;
   logic        overrun;

   modport master (
      output crc_en, data_in, err_in, crc_in,
      input  angle_out, err_out, angle_valid, crc_fail, fail_cnt,
             alarm, stale, busy, overrun
   );

   modport slave (
      input  crc_en, data_in, err_in, crc_in,
      output angle_out, err_out, angle_valid, crc_fail, fail_cnt,
             alarm, stale, busy, overrun
   );
endinterface

// File: rtl/biss_crc_check.sv
// BiSS-C CRC-6 (x^6+x+1) checker: serially recomputes the CRC over angle+status,
// publishes CRC-clean angles and tracks failure, alarm and staleness status.
module biss_crc_check #(
   parameter int unsigned FAIL_LIMIT = 3,
   parameter logic [31:0] TIMEOUT    = 32'd200000
) (
   input logic      clk,
   input logic      rst,
   biss_crc_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, CHECK} state_t;

   localparam logic [7:0] LIMIT8 = 8'(FAIL_LIMIT);

   state_t      state;
   state_t      state_nxt;
   logic        crc_en_d;
   logic        start;
   logic [27:0] sh;
   logic [5:0]  crc_ref;
   logic [5:0]  crc;
   logic [4:0]  bitcnt;
   logic        fb;
   logic        ok;
   logic [7:0]  cons_cnt;
   logic [31:0] tmo_cnt;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign start = bus.crc_en & ~crc_en_d;
   assign fb    = crc[5] ^ sh[bitcnt];
   assign ok    = (crc == crc_ref);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (bitcnt == 5'd0) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Frame capture and serial CRC, MSB first over {angle, nError, nWarn}
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (start) begin
               sh      <= {bus.data_in, bus.err_in};
               crc_ref <= bus.crc_in;
               crc     <= 6'h00;
               bitcnt  <= 5'd27;
            end
         end
         CALC: begin
            crc <= {crc[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
            if (bitcnt != 5'd0) bitcnt <= bitcnt - 5'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_en_d        <= 1'b0;
         bus.busy        <= 1'b0;
         bus.angle_valid <= 1'b0;
         bus.crc_fail    <= 1'b0;
         bus.overrun     <= 1'b0;
         bus.angle_out   <= 26'd0;
         bus.err_out     <= 2'b11;
         bus.fail_cnt    <= 16'd0;
         bus.alarm       <= 1'b0;
         bus.stale       <= 1'b0;
         cons_cnt        <= 8'd0;
         tmo_cnt         <= 32'd0;
      end else begin
         crc_en_d        <= bus.crc_en;
         bus.angle_valid <= 1'b0;
         bus.crc_fail    <= 1'b0;
         bus.overrun     <= start && (state != IDLE);

         if (state == IDLE && start)  bus.busy <= 1'b1;
         else if (state == CHECK)     bus.busy <= 1'b0;

         if (state == CHECK) begin
            if (ok) begin
               bus.angle_out   <= sh[27:2];
               bus.err_out     <= sh[1:0];
               bus.angle_valid <= 1'b1;
               cons_cnt        <= 8'd0;
               bus.alarm       <= 1'b0;
            end else begin
               bus.crc_fail <= 1'b1;
               bus.fail_cnt <= sat_inc16(bus.fail_cnt);
               cons_cnt     <= sat_inc8(cons_cnt);
               bus.alarm    <= (sat_inc8(cons_cnt) >= LIMIT8);
            end
         end

         // A good result outranks timeout saturation in the same cycle
         if (state == CHECK && ok) begin
            tmo_cnt   <= 32'd0;
            bus.stale <= 1'b0;
         end else if (tmo_cnt != TIMEOUT) begin
            tmo_cnt   <= tmo_cnt + 32'd1;
            bus.stale <= (tmo_cnt + 32'd1 == TIMEOUT);
         end
      end
   end

endmodule
